spi_master_arbiter: RTL and testbench

Shares one SPI master engine between NUM_REQ requesters, each owning its own slave select line.
- Round-robin arbitration picks one requester at a time.
- For that requester: applies its MODE, asserts its SS, starts the engine, captures the received word, releases SS, then enforces a minimum inter-frame gap.
- Sits between on-chip clients and the SPI master engine driving SClk/MOSI/MISO.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_rr_arbiter.sv | 31 +++
 rtl/spi_master_arbiter.sv | 149 ++++++++++++++
 tb/tb_spi_master_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master arbiter slice.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_XFER    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin select: first set request at or after ptr, wrapping.
module spi_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Scan from the pointer upward; the first requester found wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        winner[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master engine between NUM_REQ requesters, one frame at a time.
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 3,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic [NUM_REQ-1:0]            Req,
  input  logic [2*NUM_REQ-1:0]          ReqMode,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqTxData,
  output logic [NUM_REQ-1:0]            Grant,
  output logic [NUM_REQ-1:0]            RspValid,
  output logic [DATA_WIDTH-1:0]         RspData,
  output logic                          RspErr,
  output logic                          MStart,
  output logic [1:0]                    MMode,
  output logic [DATA_WIDTH-1:0]         MTxData,
  input  logic                          MDone,
  input  logic [DATA_WIDTH-1:0]         MRxData,
  output logic [NUM_REQ-1:0]            SSn
);

  localparam int unsigned IW = cnt_w(NUM_REQ);
  localparam int unsigned CW = cnt_w(TIMEOUT + SETUP_CYCLES + GAP_CYCLES);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] rr_ptr, owner;

  logic [NUM_REQ-1:0] win_onehot;
  logic [IW-1:0]      win_idx;
  logic               win_any;

  logic grab, fire, finish, timed_out;

  logic [1:0]            mode_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] tx_arr   [NUM_REQ];

  spi_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req    (Req),
    .ptr    (rr_ptr),
    .winner (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

  // Unpack per-requester mode and transmit slices for indexed selection.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      mode_arr[i] = ReqMode[2*i +: 2];
      tx_arr[i]   = ReqTxData[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  // Next-state logic; one shared counter times setup, transfer and gap phases.
  // A counter at TIMEOUT-1 in XFER is the expiry cycle; MDone there still wins.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    grab      = 1'b0;
    fire      = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (win_any) begin
          grab      = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt == CW'(SETUP_CYCLES - 1)) begin
          fire      = 1'b1;
          state_nxt = ST_XFER;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_XFER: begin
        if (MDone) begin
          finish    = 1'b1;
          state_nxt = ST_RELEASE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          state_nxt = ST_RELEASE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_RELEASE: state_nxt = ST_GAP;
      ST_GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      Grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      RspValid <= '0;
      RspErr   <= 1'b0;
      RspData  <= '0;
      MStart   <= 1'b0;
      MMode    <= '0;
      MTxData  <= '0;
      SSn      <= '1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      MStart   <= fire;
      RspValid <= '0;
      if (grab) begin
        Grant   <= win_onehot;
        owner   <= win_idx;
        MMode   <= mode_arr[win_idx];
        MTxData <= tx_arr[win_idx];
        SSn     <= ~win_onehot;
      end
      if (finish) begin
        SSn      <= '1;
        Grant    <= '0;
        RspValid <= Grant;
        RspErr   <= timed_out;
        RspData  <= timed_out ? '0 : MRxData;
        rr_ptr   <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter with a simple SPI engine model.
module tb_spi_master_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned SC = 2;
  localparam int unsigned GC = 3;
  localparam int unsigned TO = 16;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic [NR-1:0]     Req;
  logic [2*NR-1:0]   ReqMode;
  logic [NR*DW-1:0]  ReqTxData;
  logic [NR-1:0]     Grant, RspValid, SSn;
  logic [DW-1:0]     RspData, MTxData, MRxData;
  logic              RspErr, MStart, MDone;
  logic [1:0]        MMode;

  always #5 Clk = ~Clk;

  spi_master_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .SETUP_CYCLES (SC),
    .GAP_CYCLES   (GC),
    .TIMEOUT      (TO)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Req       (Req),
    .ReqMode   (ReqMode),
    .ReqTxData (ReqTxData),
    .Grant     (Grant),
    .RspValid  (RspValid),
    .RspData   (RspData),
    .RspErr    (RspErr),
    .MStart    (MStart),
    .MMode     (MMode),
    .MTxData   (MTxData),
    .MDone     (MDone),
    .MRxData   (MRxData),
    .SSn       (SSn)
  );

  typedef struct {
    logic [NR-1:0] grant;
    logic [1:0]    mode;
    logic [DW-1:0] tx;
  } gexp_t;

  typedef struct {
    logic [NR-1:0] valid;
    logic [DW-1:0] data;
    logic          err;
    int            lat;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  int            cyc       = 0;
  int            checks    = 0;
  int            errors    = 0;
  int            eng_delay = -1;
  logic [DW-1:0] eng_xor   = '0;
  int            stray_at  = -1;
  bit            mon_en    = 1'b0;
  int            n_start   = 0;
  int            ns;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_slice(input int i, input logic [1:0] m, input logic [DW-1:0] tx);
    ReqMode[2*i +: 2]    = m;
    ReqTxData[DW*i +: DW] = tx;
  endtask

  task automatic push_g(input logic [NR-1:0] g, input logic [1:0] m, input logic [DW-1:0] tx);
    gexp_t e;
    e.grant = g; e.mode = m; e.tx = tx;
    gq.push_back(e);
  endtask

  task automatic push_r(input logic [NR-1:0] v, input logic [DW-1:0] d, input logic err, input int lat);
    rexp_t e;
    e.valid = v; e.data = d; e.err = err; e.lat = lat;
    rq.push_back(e);
  endtask

  task automatic wait_rq(input int left, input int limit, input string name);
    while (rq.size() > left && limit > 0) begin @(negedge Clk); limit--; end
    if (rq.size() > left) chk(name, 32'(rq.size()), 32'(left));
  endtask

  task automatic wait_gq(input int limit, input string name);
    while (gq.size() > 0 && limit > 0) begin @(negedge Clk); limit--; end
    if (gq.size() > 0) chk(name, 32'(gq.size()), 32'd0);
  endtask

  task automatic wait_starts(input int target, input int limit, input string name);
    while (n_start < target && limit > 0) begin @(negedge Clk); limit--; end
    if (n_start < target) chk(name, 32'(n_start), 32'(target));
  endtask

  // Engine model: MDone eng_delay cycles after MStart, returning MTxData ^ eng_xor.
  initial begin : engine
    int            cnt;
    logic [DW-1:0] tx_hold;
    MDone   = 1'b0;
    MRxData = '0;
    cnt     = -1;
    tx_hold = '0;
    forever begin
      @(negedge Clk);
      MDone = 1'b0;
      if (cyc == stray_at) begin
        MDone   = 1'b1;
        MRxData = 8'h77;
      end
      if (MStart && eng_delay >= 0) begin
        cnt     = eng_delay;
        tx_hold = MTxData;
      end
      if (cnt == 0) begin
        MDone   = 1'b1;
        MRxData = tx_hold ^ eng_xor;
        cnt     = -1;
      end else if (cnt > 0) begin
        cnt--;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT grants or responds.
  initial begin : monitor
    logic [NR-1:0] prev_g, ss_exp, all1;
    int            g_cyc, s_cyc, r_cyc, nst;
    gexp_t         ge;
    rexp_t         re;
    prev_g = '0; all1 = '1;
    g_cyc = 0; s_cyc = 0; r_cyc = -100; nst = 0;
    wait (mon_en);
    forever begin
      @(negedge Clk);
      chk("ss_at_most_one_low", 32'($countones(~SSn) <= 1), 32'd1);
      if (Grant != '0 && prev_g == '0) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", 32'(Grant), 32'd0);
        end else begin
          ge = gq.pop_front();
          ss_exp = ~ge.grant;
          chk("grant", 32'(Grant), 32'(ge.grant));
          chk("mmode", 32'(MMode), 32'(ge.mode));
          chk("mtxdata", 32'(MTxData), 32'(ge.tx));
          chk("ssn_owner", 32'(SSn), 32'(ss_exp));
        end
        chk("gap_len", 32'((cyc - r_cyc) >= int'(GC + 1)), 32'd1);
        g_cyc = cyc;
        nst   = 0;
      end
      if (MStart) begin
        chk("mstart_once", 32'(nst), 32'd0);
        chk("setup_len", 32'(cyc - g_cyc), 32'(SC));
        nst++;
        s_cyc = cyc;
        n_start++;
      end
      if (RspValid != '0) begin
        if (rq.size() == 0) begin
          chk("unexpected_rsp", 32'(RspValid), 32'd0);
        end else begin
          re = rq.pop_front();
          chk("rspvalid", 32'(RspValid), 32'(re.valid));
          chk("rspdata", 32'(RspData), 32'(re.data));
          chk("rsperr", 32'(RspErr), 32'(re.err));
          chk("rsp_latency", 32'(cyc - s_cyc), 32'(re.lat));
          chk("release_ssn", 32'(SSn), 32'(all1));
          chk("release_grant", 32'(Grant), 32'd0);
        end
        r_cyc = cyc;
      end
      prev_g = Grant;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    Rst_n = 1'b0; Req = '0; ReqMode = '0; ReqTxData = '0;
    for (int i = 0; i < int'(NR); i++) set_slice(i, 2'(i), DW'(8'h10 + i));
    repeat (3) @(negedge Clk);
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_rspvalid", 32'(RspValid), 32'd0);
    chk("rst_rsperr", 32'(RspErr), 32'd0);
    chk("rst_rspdata", 32'(RspData), 32'd0);
    chk("rst_mstart", 32'(MStart), 32'd0);
    chk("rst_mmode", 32'(MMode), 32'd0);
    chk("rst_mtxdata", 32'(MTxData), 32'd0);
    chk("rst_ssn", 32'(SSn), 32'hF);
    Rst_n  = 1'b1;
    mon_en = 1'b1;

    // All requesting: rotation 0,1,2,3,0,1,2,3 from pointer 0.
    eng_delay = 3; eng_xor = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      push_g(NR'(1 << (k % 4)), 2'(k % 4), DW'(8'h10 + k % 4));
      push_r(NR'(1 << (k % 4)), DW'(8'h10 + k % 4) ^ 8'hFF, 1'b0, 4);
    end
    Req = 4'b1111;
    wait_gq(400, "rr_grant_wait");
    Req = '0;
    wait_rq(0, 200, "rr_rsp_wait");

    // Single request from requester 2: mode 3, A5 out, 3C back.
    set_slice(2, 2'b11, 8'hA5);
    eng_delay = 12; eng_xor = 8'h99;
    push_g(4'b0100, 2'b11, 8'hA5);
    push_r(4'b0100, 8'h3C, 1'b0, 13);
    Req = 4'b0100;
    wait_gq(50, "single_grant_wait");
    Req = '0;
    wait_rq(0, 100, "single_rsp_wait");
    repeat (GC) begin
      @(negedge Clk);
      chk("post_frame_ssn", 32'(SSn), 32'hF);
    end

    // Timeout on requester 3, then requester 0 served normally.
    eng_delay = -1; eng_xor = 8'hFF;
    push_g(4'b1000, 2'b11, 8'h13);
    push_g(4'b0001, 2'b00, 8'h10);
    push_r(4'b1000, 8'h00, 1'b1, 16);
    push_r(4'b0001, 8'hEF, 1'b0, 6);
    Req = 4'b1001;
    wait_rq(1, 100, "timeout_rsp_wait");
    eng_delay = 5;
    wait_gq(50, "after_timeout_grant_wait");
    Req = '0;
    wait_rq(0, 100, "after_timeout_rsp_wait");

    // Requester 1 drops Req in XFER; MDone lands on the expiry cycle.
    eng_delay = 15;
    push_g(4'b0010, 2'b01, 8'h11);
    push_r(4'b0010, 8'hEE, 1'b0, 16);
    Req = 4'b0010;
    ns = n_start;
    wait_starts(ns + 1, 50, "drop_start_wait");
    Req = '0;
    wait_rq(0, 100, "drop_rsp_wait");
    repeat (10) @(negedge Clk);
    chk("no_regrant", 32'(Grant), 32'd0);

    // Stray MDone while idle must change nothing.
    stray_at = cyc + 3;
    repeat (8) @(negedge Clk);
    chk("stray_rspdata", 32'(RspData), 32'hEE);
    chk("stray_grant", 32'(Grant), 32'd0);
    chk("stray_ssn", 32'(SSn), 32'hF);

    // Reset in the middle of XFER, then re-grant of requester 0.
    eng_delay = -1;
    push_g(4'b0001, 2'b00, 8'h10);
    Req = 4'b0001;
    ns = n_start;
    wait_starts(ns + 1, 50, "reset_start_wait");
    repeat (2) @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    chk("midrst_ssn", 32'(SSn), 32'hF);
    chk("midrst_grant", 32'(Grant), 32'd0);
    chk("midrst_rspvalid", 32'(RspValid), 32'd0);
    chk("midrst_mstart", 32'(MStart), 32'd0);
    eng_delay = 4; eng_xor = 8'h0F;
    push_g(4'b0001, 2'b00, 8'h10);
    push_r(4'b0001, 8'h1F, 1'b0, 5);
    Rst_n = 1'b1;
    wait_gq(50, "regrant_wait");
    Req = '0;
    wait_rq(0, 100, "regrant_rsp_wait");
    repeat (5) @(negedge Clk);

    chk("grant_queue_empty", 32'(gq.size()), 32'd0);
    chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
